// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and strobes, handshakes with a variable-latency memory.
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int HAS_JAL     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_source_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic             err_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    state_t            state;
    state_t            next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;

    // The cycle that exhausts the wait budget traps instead of completing.
    always_comb begin
        waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        timeout = (MEM_TIMEOUT > 0) && waiting && !mem_ready_i &&
                  (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:    if (mem_ready_i) next = S_DECODE;
            S_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE:        next = (funct_i == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:    next = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI: next = S_EXEC_I;
                    OP_BEQ, OP_BNE:  next = S_BRANCH;
                    OP_J:            next = S_JUMP;
                    OP_JAL:          next = (HAS_JAL != 0) ? S_JUMP : S_ERROR;
                    default:         next = S_ERROR;
                endcase
            end
            S_MEM_ADDR: next = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) next = S_FETCH;
            S_EXEC_R:   next = S_R_WB;
            S_EXEC_I:   next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: next = S_FETCH;
            S_ERROR:    next = S_ERROR;
            default:    next = S_ERROR;
        endcase
        if (timeout) next = S_ERROR;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            instr_count_o <= '0;
            err_o         <= 1'b0;
        end else begin
            state <= next;
            err_o <= err_o | (next == S_ERROR);
            wait_cnt <= (waiting && !mem_ready_i) ? wait_cnt + WAIT_W'(1) : '0;
            if (next == S_FETCH && state != S_FETCH)
                instr_count_o <= instr_count_o + CNT_W'(1);
        end
    end

    assign state_o = state;

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_source_o  = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE:   alu_src_b_o = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b01;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
            end
            S_I_WB:     reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b001;
                pc_source_o = 2'b01;
                pc_write_o  = ((instr_op_i == OP_BEQ) && zero_i) ||
                              ((instr_op_i == OP_BNE) && !zero_i);
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
                // jal links through the already-incremented PC.
                if (instr_op_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'b10;
                    mem_to_reg_o = 2'b10;
                end
            end
            S_JR: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b11;
            end
            default: ;
        endcase
        if (timeout) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            reg_write_o = 1'b0;
        end
        // Quiet datapath while reset is asserted.
        if (rst_i) begin
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            iord_o       = 1'b0;
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            pc_source_o  = 2'b00;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 3'b000;
            reg_write_o  = 1'b0;
            reg_dst_o    = 2'b00;
            mem_to_reg_o = 2'b00;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus random instruction streams checked
// against an instruction-level plan model; a second instance covers HAS_JAL=0.
module tb_multi_cycle_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [5:0]  instr_op_i;
    logic [5:0]  funct_i;
    logic        zero_i;
    logic        mem_ready_i;

    logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_source_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
    logic        alu_src_a_o, reg_write_o, err_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic [31:0] instr_count_o;

    logic        nj_mem_req, nj_mem_we, nj_iord, nj_ir_write, nj_pc_write;
    logic [1:0]  nj_pc_source, nj_alu_src_b, nj_reg_dst, nj_mem_to_reg;
    logic        nj_alu_src_a, nj_reg_write, nj_err;
    logic [2:0]  nj_alu_op;
    logic [3:0]  nj_state;
    logic [31:0] nj_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 0;
    bit          rdy_q[$];

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32), .HAS_JAL(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
        .pc_write_o(pc_write_o), .pc_source_o(pc_source_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .reg_write_o(reg_write_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .state_o(state_o),
        .instr_count_o(instr_count_o), .err_o(err_o)
    );

    multi_cycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(32), .HAS_JAL(0)) dut_nj (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(nj_mem_req),
        .mem_we_o(nj_mem_we), .iord_o(nj_iord), .ir_write_o(nj_ir_write),
        .pc_write_o(nj_pc_write), .pc_source_o(nj_pc_source), .alu_src_a_o(nj_alu_src_a),
        .alu_src_b_o(nj_alu_src_b), .alu_op_o(nj_alu_op), .reg_write_o(nj_reg_write),
        .reg_dst_o(nj_reg_dst), .mem_to_reg_o(nj_mem_to_reg), .state_o(nj_state),
        .instr_count_o(nj_count), .err_o(nj_err)
    );

    logic [18:0] got_bus, nj_bus;
    assign got_bus = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_source_o,
                      alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
                      mem_to_reg_o, err_o};
    assign nj_bus  = {nj_mem_req, nj_mem_we, nj_iord, nj_ir_write, nj_pc_write, nj_pc_source,
                      nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_reg_write, nj_reg_dst,
                      nj_mem_to_reg, nj_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control bundle for one cycle of a given phase, straight from the output tables.
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op,
                                            input logic z, input bit rdy, input bit fire);
        logic mreq, mwe, iord, irw, pcw, asa, rw, err;
        logic [1:0] pcs, asb, rd, m2r;
        logic [2:0] aop;
        {mreq, mwe, iord, irw, pcw, asa, rw, err} = '0;
        {pcs, asb, rd, m2r} = '0;
        aop = 3'b000;
        case (st)
            0:  begin mreq = !fire; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = !fire; iord = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mreq = !fire; mwe = !fire; iord = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; asb = 2'b10; aop = (op == 6'h0A) ? 3'b011 : 3'b000; end
            9:  rw = 1;
            10: begin asa = 1; aop = 3'b001; pcs = 2'b01;
                      pcw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
            11: begin pcw = 1; pcs = 2'b10;
                      if (op == 6'h03) begin rw = 1; rd = 2'b10; m2r = 2'b10; end end
            12: begin pcw = 1; pcs = 2'b11; end
            15: err = 1;
            default: ;
        endcase
        return {mreq, mwe, iord, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, err};
    endfunction

    function automatic bit next_rdy();
        if (rdy_q.size() > 0) return rdy_q.pop_front();
        return ($urandom_range(0, 9) < 7);
    endfunction

    task automatic check_cycle(input int st, input logic [18:0] bus);
        @(negedge clk);
        chk($sformatf("st%0d_state", st), {28'b0, state_o}, st);
        chk($sformatf("st%0d_ctl", st), {13'b0, got_bus}, {13'b0, bus});
        chk($sformatf("st%0d_count", st), instr_count_o, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    // One phase of an instruction; memory phases repeat until ready, a trap, or the limit.
    task automatic do_step(input int st, input logic [5:0] op, input logic z, input bit is_wait,
                           input int limit, output bit trapped, output bit stalled);
        int low = 0;
        int n = 0;
        bit rdy, fire;
        trapped = 0;
        stalled = 0;
        forever begin
            rdy = next_rdy();
            mem_ready_i = rdy;
            zero_i = z;
            n++;
            if (!rdy) low++;
            fire = is_wait && !rdy && (TO > 0) && (low == TO);
            check_cycle(st, exp_out(st, op, z, rdy, fire));
            if (fire) begin trapped = 1; break; end
            if (!is_wait || rdy) break;
            if (limit > 0 && n >= limit) begin stalled = 1; break; end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        mem_ready_i = $urandom_range(0, 1);
        @(negedge clk);
        chk("rst_ctl", {14'b0, got_bus[18:1]}, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic error_tail(input logic [5:0] op, input logic z);
        bit tr, sl;
        repeat (3) do_step(15, op, z, 0, 0, tr, sl);
        do_reset();
    endtask

    // Instruction-level plan: phase list per opcode class.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bit tr, sl, bad;
        bad = 0;
        instr_op_i = op;
        funct_i = fn;
        do_step(0, op, z, 1, 0, tr, sl);
        if (tr) begin error_tail(op, z); return; end
        do_step(1, op, z, 0, 0, tr, sl);
        case (op)
            6'h00: if (fn == 6'h08) do_step(12, op, z, 0, 0, tr, sl);
                   else begin do_step(6, op, z, 0, 0, tr, sl); do_step(7, op, z, 0, 0, tr, sl); end
            6'h23: begin
                do_step(2, op, z, 0, 0, tr, sl);
                do_step(3, op, z, 1, 0, tr, sl);
                if (tr) bad = 1;
                else do_step(4, op, z, 0, 0, tr, sl);
            end
            6'h2B: begin
                do_step(2, op, z, 0, 0, tr, sl);
                do_step(5, op, z, 1, 0, tr, sl);
                if (tr) bad = 1;
            end
            6'h08, 6'h0A: begin do_step(8, op, z, 0, 0, tr, sl); do_step(9, op, z, 0, 0, tr, sl); end
            6'h04, 6'h05: do_step(10, op, z, 0, 0, tr, sl);
            6'h02, 6'h03: do_step(11, op, z, 0, 0, tr, sl);
            default: bad = 1;
        endcase
        if (bad) error_tail(op, z);
        else exp_cnt++;
    endtask

    task automatic push_ones(input int n);
        for (int i = 0; i < n; i++) rdy_q.push_back(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [12];
        logic [5:0] op, fn;
        logic [31:0] cnt_before;
        bit tr, sl;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02, 6'h03,
                6'h3F, 6'h11};
        rst_i = 1'b1; instr_op_i = 0; funct_i = 0; zero_i = 0; mem_ready_i = 0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_state", {28'b0, state_o}, 32'd0);
        chk("reset_count", instr_count_o, 32'd0);
        chk("reset_err", {31'b0, err_o}, 32'd0);

        // add, memory always ready
        push_ones(5);
        run_instr(6'h00, 6'h20, 1'b0);
        chk("add_retired", instr_count_o, 32'd1);

        // jal: legal on main instance, illegal on the HAS_JAL=0 instance
        cnt_before = exp_cnt;
        push_ones(4);
        run_instr(6'h03, 6'h00, 1'b0);
        chk("nj_state", {28'b0, nj_state}, 32'd15);
        chk("nj_bus", {13'b0, nj_bus}, {13'b0, exp_out(15, 6'h03, 1'b0, 1'b0, 1'b0)});
        chk("nj_count", nj_count, cnt_before);
        push_ones(5);
        run_instr(6'h00, 6'h20, 1'b0);
        chk("nj_sticky_state", {28'b0, nj_state}, 32'd15);
        chk("nj_sticky_err", {31'b0, nj_err}, 32'd1);
        do_reset();
        chk("nj_reset_state", {28'b0, nj_state}, 32'd0);
        chk("nj_reset_err", {31'b0, nj_err}, 32'd0);

        // lw with three stalled memory cycles
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(6'h23, 6'h00, 1'b0);

        // branches
        push_ones(3); run_instr(6'h04, 6'h00, 1'b1);
        push_ones(3); run_instr(6'h04, 6'h00, 1'b0);
        push_ones(3); run_instr(6'h05, 6'h00, 1'b0);
        push_ones(3); run_instr(6'h05, 6'h00, 1'b1);

        // fetch timeout
        rdy_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_instr(6'h00, 6'h20, 1'b0);

        // reset while a store waits on memory
        push_ones(3);
        instr_op_i = 6'h2B; funct_i = 6'h00;
        do_step(0, 6'h2B, 1'b0, 1, 0, tr, sl);
        do_step(1, 6'h2B, 1'b0, 0, 0, tr, sl);
        do_step(2, 6'h2B, 1'b0, 0, 0, tr, sl);
        rdy_q = '{1'b0, 1'b0};
        do_step(5, 6'h2B, 1'b0, 1, 2, tr, sl);
        do_reset();
        chk("rst_mid_state", {28'b0, state_o}, 32'd0);
        chk("rst_mid_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_mid_count", instr_count_o, 32'd0);
        chk("rst_mid_err", {31'b0, err_o}, 32'd0);

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
